// File: rtl/bcd_count_ctrl.sv
// bcd_count_ctrl: four-bit count sequencer for the two-digit 7-segment decoder.
// Raw active-low buttons are synchronised and debounced. Slide switches are synchronised only.
// Manual mode steps the count on each button press.
// Auto mode steps the count on a prescaled tick and supports run/hold.
// The count range is configured by the BCD_DECIMAL_EN macro:
//   defined   -> the count runs 0..9
//   undefined -> the count runs 0..15 (full hex)

// Debouncer for one synchronised active-low button; emits a one-cycle press pulse.
module bcd_count_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic synced,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt;
    logic          level;

    // Count how long the input has disagreed with the accepted level; flip once it has been stable long enough.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (synced == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= synced;
                press <= ~synced;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

endmodule

module bcd_count_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TICK_CYCLES     = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up_n,
    input  logic       btn_dn_n,
    input  logic       sw_auto,
    input  logic       sw_dir,
    output logic [3:0] bcd,
    output logic       wrap,
    output logic [1:0] mode
);

`ifdef BCD_DECIMAL_EN
    localparam logic [3:0] MAX_VAL = 4'd9;
`else
    localparam logic [3:0] MAX_VAL = 4'd15;
`endif

    localparam int PW = $clog2(TICK_CYCLES);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

    typedef enum logic [1:0] {
        ST_MANUAL    = 2'b00,
        ST_AUTO_RUN  = 2'b01,
        ST_AUTO_HOLD = 2'b10
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [1:0]    up_sync;
    logic [1:0]    dn_sync;
    logic [1:0]    auto_sync;
    logic [1:0]    dir_sync;

    logic          press_up;
    logic          press_dn;

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nx;
    logic [3:0]    bcd_nx;
    logic          wrap_nx;

    logic          sw_auto_s;
    logic          sw_dir_s;
    logic          tick;
    logic          do_inc;
    logic          do_dec;
    logic          do_clear;

    assign sw_auto_s = auto_sync[1];
    assign sw_dir_s  = dir_sync[1];
    assign tick      = (state == ST_AUTO_RUN) && (presc == PRESC_LAST);
    assign mode      = state;

    // Two-flop synchronisers; buttons idle released, switches idle low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            up_sync   <= 2'b11;
            dn_sync   <= 2'b11;
            auto_sync <= 2'b00;
            dir_sync  <= 2'b00;
        end else begin
            up_sync   <= {up_sync[0], btn_up_n};
            dn_sync   <= {dn_sync[0], btn_dn_n};
            auto_sync <= {auto_sync[0], sw_auto};
            dir_sync  <= {dir_sync[0], sw_dir};
        end
    end

    bcd_count_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_up (
        .clk    (clk),
        .rst_n  (rst_n),
        .synced (up_sync[1]),
        .press  (press_up)
    );

    bcd_count_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_dn (
        .clk    (clk),
        .rst_n  (rst_n),
        .synced (dn_sync[1]),
        .press  (press_dn)
    );

    // Mode register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_MANUAL;
        end else begin
            state <= state_nx;
        end
    end

    // Next mode, prescaler and count; leaving auto mode overrides any press in the same cycle.
    always_comb begin
        state_nx = state;
        presc_nx = presc;
        do_inc   = 1'b0;
        do_dec   = 1'b0;
        do_clear = 1'b0;
        bcd_nx   = bcd;
        wrap_nx  = 1'b0;

        case (state)
            ST_MANUAL: begin
                presc_nx = '0;
                if (sw_auto_s) begin
                    state_nx = ST_AUTO_RUN;
                end
                if (press_up && !press_dn) begin
                    do_inc = 1'b1;
                end else if (press_dn && !press_up) begin
                    do_dec = 1'b1;
                end
            end
            ST_AUTO_RUN: begin
                if (!sw_auto_s) begin
                    state_nx = ST_MANUAL;
                    presc_nx = '0;
                end else begin
                    presc_nx = tick ? '0 : presc + PRESC_ONE;
                    if (tick) begin
                        do_inc = sw_dir_s;
                        do_dec = ~sw_dir_s;
                    end
                    if (press_up) begin
                        state_nx = ST_AUTO_HOLD;
                    end
                    if (press_dn) begin
                        do_clear = 1'b1;
                        presc_nx = '0;
                    end
                end
            end
            ST_AUTO_HOLD: begin
                if (!sw_auto_s) begin
                    state_nx = ST_MANUAL;
                    presc_nx = '0;
                end else begin
                    if (press_up) begin
                        state_nx = ST_AUTO_RUN;
                    end
                    if (press_dn) begin
                        do_clear = 1'b1;
                        presc_nx = '0;
                    end
                end
            end
            default: begin
                state_nx = ST_MANUAL;
                presc_nx = '0;
            end
        endcase

        if (do_clear) begin
            bcd_nx = 4'd0;
        end else if (do_inc) begin
            if (bcd >= MAX_VAL) begin
                bcd_nx  = 4'd0;
                wrap_nx = 1'b1;
            end else begin
                bcd_nx = bcd + 4'd1;
            end
        end else if (do_dec) begin
            if (bcd == 4'd0) begin
                bcd_nx  = MAX_VAL;
                wrap_nx = 1'b1;
            end else begin
                bcd_nx = bcd - 4'd1;
            end
        end
    end

    // Count, wrap pulse and prescaler registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd   <= 4'd0;
            wrap  <= 1'b0;
            presc <= '0;
        end else begin
            bcd   <= bcd_nx;
            wrap  <= wrap_nx;
            presc <= presc_nx;
        end
    end

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// tb_bcd_count_ctrl: directed bench for bcd_count_ctrl with short debounce and tick periods.
module tb_bcd_count_ctrl;

    localparam int DEB  = 4;
    localparam int TICK = 8;

`ifdef BCD_DECIMAL_EN
    localparam logic [3:0] MAXV = 4'd9;
`else
    localparam logic [3:0] MAXV = 4'd15;
`endif

    logic       clk;
    logic       rst_n;
    logic       btn_up_n;
    logic       btn_dn_n;
    logic       sw_auto;
    logic       sw_dir;
    logic [3:0] bcd;
    logic       wrap;
    logic [1:0] mode;

    int vectors;
    int miscompares;

    bcd_count_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .TICK_CYCLES    (TICK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_up_n (btn_up_n),
        .btn_dn_n (btn_dn_n),
        .sw_auto  (sw_auto),
        .sw_dir   (sw_dir),
        .bcd      (bcd),
        .wrap     (wrap),
        .mode     (mode)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive all user inputs, then advance the given number of rising edges and settle 1 time unit.
    task automatic applyStimulus(input logic up_n, input logic dn_n, input logic a, input logic d,
                                 input int edges);
        btn_up_n = up_n;
        btn_dn_n = dn_n;
        sw_auto  = a;
        sw_dir   = d;
        repeat (edges) @(posedge clk);
        #1;
    endtask

    // Compare one observed output against its hand-computed value.
    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Manual-mode press: count and wrap checked on edge 7 after the pin falls, wrap must drop next cycle.
    task automatic pressAndCheck(input string tag, input logic up, input logic dn,
                                 input logic [3:0] exp_bcd, input logic exp_wrap);
        applyStimulus(~up, ~dn, 1'b0, 1'b0, 7);
        checkOutput({tag, "_bcd"}, bcd, exp_bcd);
        checkOutput({tag, "_wrap"}, {3'b0, wrap}, {3'b0, exp_wrap});
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1);
        checkOutput({tag, "_wrap_off"}, {3'b0, wrap}, 4'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 7);
    endtask

    // Directed sequence: reset, manual stepping, bounce, auto run/hold, clear, reset, mode priority.
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        applyStimulus(1, 1, 0, 0, 3);
        checkOutput("reset_bcd", bcd, 4'd0);
        checkOutput("reset_wrap", {3'b0, wrap}, 4'd0);
        checkOutput("reset_mode", {2'b0, mode}, 4'd0);
        rst_n = 1'b1;

        applyStimulus(0, 1, 0, 0, 6);
        checkOutput("lat_edge6", bcd, 4'd0);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("lat_edge7", bcd, 4'd1);
        checkOutput("lat_wrap", {3'b0, wrap}, 4'd0);
        applyStimulus(0, 1, 0, 0, 10);
        checkOutput("hold_no_repeat", bcd, 4'd1);
        applyStimulus(1, 1, 0, 0, 8);
        checkOutput("release_no_step", bcd, 4'd1);

        pressAndCheck("dn_1to0", 1'b0, 1'b1, 4'd0, 1'b0);
        pressAndCheck("dn_wrap", 1'b0, 1'b1, MAXV, 1'b1);
        pressAndCheck("up_wrap", 1'b1, 1'b0, 4'd0, 1'b1);
        pressAndCheck("dn_wrap2", 1'b0, 1'b1, MAXV, 1'b1);
        pressAndCheck("up_wrap2", 1'b1, 1'b0, 4'd0, 1'b1);
        pressAndCheck("up_to1", 1'b1, 1'b0, 4'd1, 1'b0);
        pressAndCheck("up_to2", 1'b1, 1'b0, 4'd2, 1'b0);
        pressAndCheck("up_to3", 1'b1, 1'b0, 4'd3, 1'b0);
        pressAndCheck("both_pressed", 1'b1, 1'b1, 4'd3, 1'b0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 0, 0, 2);
            applyStimulus(1, 1, 0, 0, 2);
        end
        applyStimulus(1, 1, 0, 0, 8);
        checkOutput("bounce_bcd", bcd, 4'd3);

        applyStimulus(1, 1, 1, 1, 2);
        checkOutput("auto_sync_mode0", {2'b0, mode}, 4'd0);
        applyStimulus(1, 1, 1, 1, 1);
        checkOutput("auto_run_mode", {2'b0, mode}, 4'd1);
        applyStimulus(1, 1, 1, 1, 7);
        checkOutput("tick_before", bcd, 4'd3);
        applyStimulus(1, 1, 1, 1, 1);
        checkOutput("tick1_bcd", bcd, 4'd4);
        checkOutput("tick1_wrap", {3'b0, wrap}, 4'd0);
        applyStimulus(1, 1, 1, 1, 8);
        checkOutput("tick2_bcd", bcd, 4'd5);

        applyStimulus(1, 1, 1, 1, 1);
        applyStimulus(0, 1, 1, 1, 7);
        checkOutput("hold_tick_bcd", bcd, 4'd6);
        checkOutput("hold_mode", {2'b0, mode}, 4'd2);
        applyStimulus(1, 1, 1, 1, 8);
        applyStimulus(1, 1, 1, 1, 32);
        checkOutput("hold_frozen_bcd", bcd, 4'd6);
        checkOutput("hold_frozen_mode", {2'b0, mode}, 4'd2);

        applyStimulus(0, 1, 1, 1, 7);
        checkOutput("resume_mode", {2'b0, mode}, 4'd1);
        checkOutput("resume_bcd", bcd, 4'd6);
        applyStimulus(1, 1, 1, 1, 7);
        checkOutput("resume_before", bcd, 4'd6);
        applyStimulus(1, 1, 1, 1, 1);
        checkOutput("resume_step", bcd, 4'd7);

        applyStimulus(1, 1, 1, 1, 1);
        applyStimulus(1, 0, 1, 1, 7);
        checkOutput("clear_bcd", bcd, 4'd0);
        checkOutput("clear_wrap", {3'b0, wrap}, 4'd0);
        checkOutput("clear_mode", {2'b0, mode}, 4'd1);
        applyStimulus(1, 1, 1, 0, 7);
        checkOutput("down_before", bcd, 4'd0);
        applyStimulus(1, 1, 1, 0, 1);
        checkOutput("down_wrap_bcd", bcd, MAXV);
        checkOutput("down_wrap_pulse", {3'b0, wrap}, 4'd1);
        applyStimulus(1, 1, 1, 0, 1);
        checkOutput("down_wrap_off", {3'b0, wrap}, 4'd0);

        rst_n = 1'b0;
        applyStimulus(1, 1, 1, 0, 1);
        checkOutput("midreset_bcd", bcd, 4'd0);
        checkOutput("midreset_mode", {2'b0, mode}, 4'd0);
        checkOutput("midreset_wrap", {3'b0, wrap}, 4'd0);
        rst_n = 1'b1;
        applyStimulus(1, 1, 1, 0, 3);
        checkOutput("rerun_mode", {2'b0, mode}, 4'd1);
        applyStimulus(1, 1, 1, 0, 8);
        checkOutput("rerun_bcd", bcd, MAXV);
        checkOutput("rerun_wrap", {3'b0, wrap}, 4'd1);

        applyStimulus(0, 1, 1, 0, 7);
        checkOutput("hold2_mode", {2'b0, mode}, 4'd2);
        checkOutput("hold2_bcd", bcd, MAXV);
        applyStimulus(1, 1, 1, 0, 8);
        applyStimulus(1, 1, 1, 0, 10);
        checkOutput("hold2_frozen", bcd, MAXV);

        applyStimulus(0, 1, 1, 0, 4);
        applyStimulus(0, 1, 0, 0, 3);
        checkOutput("exit_prio_mode", {2'b0, mode}, 4'd0);
        checkOutput("exit_prio_bcd", bcd, MAXV);
        applyStimulus(1, 1, 0, 0, 8);
        checkOutput("manual_again_mode", {2'b0, mode}, 4'd0);
        pressAndCheck("final_up", 1'b1, 1'b0, 4'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bcd_count_ctrl.md
Name: bcd_count_ctrl

Overview:
Sequencer that produces the 4-bit BCD value driving the two-digit 7-segment decoder on the lab board. Takes raw active-low pushbuttons and slide switches. Supports two modes: manual stepping (up/down buttons) and automatic counting (prescaled tick, selectable direction, run/hold). All user inputs are synchronised and buttons are debounced; the output is registered and feeds the decoder directly.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a button change (10 ms at 50 MHz); must be >=1
TICK_CYCLES, 50000000, clock cycles per auto-count step (1 s at 50 MHz); must be >=2

Ports:
clk  in  1  system clock, single clock domain
rst_n  in  1  synchronous reset, active-low
btn_up_n  in  1  raw pushbutton, active-low, asynchronous, bouncy
btn_dn_n  in  1  raw pushbutton, active-low, asynchronous, bouncy
sw_auto  in  1  slide switch, asynchronous: 1 = auto mode, 0 = manual
sw_dir  in  1  slide switch, asynchronous: 1 = count up, 0 = count down (auto mode only)
bcd  out  4  count value to the decoder, registered
wrap  out  1  one-cycle pulse on count wrap-around
mode  out  2  state: 00 MANUAL, 01 AUTO_RUN, 10 AUTO_HOLD

Behaviour:
- Reset:
  - Synchronous: applied on a clk edge with rst_n=0.
  - Clears bcd=0, wrap=0, mode=MANUAL, prescaler=0, debounce counters=0.
  - Button sync/debounced state set to released (1); sw_auto/sw_dir sync flops set to 0.
  - Reset mid-operation discards any pending press or tick.
- Synchronisers: every input passes through a 2-flop synchroniser. Only buttons are debounced.
- Debounce, per button:
  - Counter increments while the synced value differs from the debounced state; it clears when they are equal.
  - When the counter is at DEBOUNCE_CYCLES-1 and the values still differ, the debounced state flips and the counter clears.
  - A debounced 1->0 flip asserts a registered one-cycle press pulse on that same edge. Release produces no pulse.
- Latency: taking edge 1 as the first edge that samples the pin low (stable), bcd changes on edge DEBOUNCE_CYCLES+3.
- FSM, evaluated on the synced sw_auto:
  - MANUAL -> AUTO_RUN when sw_auto=1. Prescaler is cleared on entry.
  - AUTO_RUN or AUTO_HOLD -> MANUAL when sw_auto=0. This has priority over any press in the same cycle.
  - AUTO_RUN -> AUTO_HOLD on up press; AUTO_HOLD -> AUTO_RUN on up press.
- Counting:
  - MANUAL: up press gives bcd+1, dn press gives bcd-1. Up and dn pressed in the same cycle: no change. Prescaler held at 0.
  - AUTO_RUN: prescaler counts 0..TICK_CYCLES-1. On the edge where it wraps, bcd steps by +1 (sw_dir=1) or -1 (sw_dir=0). First step comes TICK_CYCLES cycles after entering AUTO_RUN.
  - AUTO_HOLD: prescaler and bcd frozen.
  - Auto modes: dn press clears bcd=0 and prescaler=0; state unchanged; no wrap pulse.
  - dn press and tick in the same cycle: clear wins.
  - Up press and tick in the same cycle (AUTO_RUN): tick applied, then state becomes AUTO_HOLD.
- Range: 0..MAX with MAX=15, modular.
  - Incrementing from MAX gives 0; decrementing from 0 gives MAX.
  - wrap pulses high for exactly the cycle after the edge that performs either wrap.
- Width: prescaler counter is $clog2(TICK_CYCLES) bits; debounce counters are $clog2(DEBOUNCE_CYCLES+1) bits.

Optional Feature:
BCD_DECIMAL_EN
- Defined: MAX=9. Count wraps 9->0 up and 0->9 down. A value >9 can never appear on bcd.
- Undefined: MAX=15, full hex range (decoder shows 10..15 as two digits).

Test Plan:
- DEBOUNCE_CYCLES=4, TICK_CYCLES=8 for all tests. Reset, then hold btn_up_n=0 -> bcd 0->1 exactly on edge 7 after the pin falls; wrap=0; further holding gives no more steps.
- Manual, bcd=15 (macro off): up press -> bcd=0, wrap high one cycle. Then dn press -> bcd=15, wrap high one cycle. With BCD_DECIMAL_EN: bcd=9 + up -> 0, and 0 + dn -> 9.
- Bounce: btn_up_n toggles every 2 cycles for 20 cycles, then stays high -> bcd unchanged, no press pulse.
- sw_auto=1, sw_dir=1, bcd=3 -> mode=01 after sync; bcd=4 after 8 cycles, 5 after 16. Up press -> mode=10 and bcd frozen for 40 cycles. Up press again -> resumes, next step 8 cycles later.
- AUTO_RUN with dn press landing on the same edge as a tick -> bcd=0, no wrap, mode stays 01. sw_dir=0 from bcd=0 -> next tick gives bcd=15 and wrap.
- Mid-count, drive rst_n=0 for one edge -> bcd=0, mode=00, wrap=0. Set sw_auto=0 while in AUTO_HOLD simultaneously with an up press -> mode=00, bcd unchanged.
